// File: rtl/stream_frame_sequencer_if.sv
// Stream and bank signal bundle between the frame sequencer (master) and its
// FIFO pair / operand-result banks (slave).
interface stream_frame_sequencer_if #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 10
) ();
    logic [DATA_WIDTH-1:0] mm2s_tdata;
    logic                  mm2s_tvalid;
    logic                  mm2s_tlast;
    logic                  mm2s_tready;

    logic                  bank_wr_en;
    logic [ADDR_WIDTH-1:0] bank_wr_addr;
    logic [DATA_WIDTH-1:0] bank_wr_data;

    logic                  bank_rd_en;
    logic [ADDR_WIDTH-1:0] bank_rd_addr;
    logic [DATA_WIDTH-1:0] bank_rd_data;

    logic [DATA_WIDTH-1:0] s2mm_tdata;
    logic                  s2mm_tvalid;
    logic                  s2mm_tlast;
    logic                  s2mm_tready;

    modport master (
        input  mm2s_tdata, mm2s_tvalid, mm2s_tlast,
        output mm2s_tready,
        output bank_wr_en, bank_wr_addr, bank_wr_data,
        output bank_rd_en, bank_rd_addr,
        input  bank_rd_data,
        output s2mm_tdata, s2mm_tvalid, s2mm_tlast,
        input  s2mm_tready
    );

    modport slave (
        output mm2s_tdata, mm2s_tvalid, mm2s_tlast,
        input  mm2s_tready,
        input  bank_wr_en, bank_wr_addr, bank_wr_data,
        input  bank_rd_en, bank_rd_addr,
        output bank_rd_data,
        input  s2mm_tdata, s2mm_tvalid, s2mm_tlast,
        output s2mm_tready
    );
endinterface

// File: rtl/stream_frame_sequencer.sv
// Frame sequencer: LOAD words from MM2S into the operand bank, kick the compute
// core, then STORE the result bank into S2MM through a 2-entry output FIFO.
module stream_frame_sequencer #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] load_len,
    input  logic [LEN_WIDTH-1:0] store_len,
    output logic                 busy,
    output logic                 done,
    output logic                 tlast_err,
    output logic                 compute_start,
    input  logic                 compute_done,
    stream_frame_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CSTART = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    logic [2:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  load_len_q, load_len_d;
    logic [LEN_WIDTH-1:0]  store_len_q, store_len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
    logic                  tlast_err_q, tlast_err_d;
    logic                  rd_vld_p1_q, rd_vld_p1_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [DATA_WIDTH-1:0] fifo_data_d [2];
    logic                  fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic                  fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    logic       mm2s_hs, last_load, s2mm_valid, push, pop, last_pop, rd_issue;
    logic [2:0] occ;

    always_comb begin
        mm2s_hs    = (state_q == S_LOAD) && bus.mm2s_tvalid;
        last_load  = (cnt_q == load_len_q - LEN_ONE);
        s2mm_valid = (fifo_cnt_q != 2'd0);
        push       = rd_vld_p1_q;
        pop        = s2mm_valid && bus.s2mm_tready;
        last_pop   = pop && (pop_cnt_q == store_len_q - LEN_ONE);
        // A read may only be issued if its word is guaranteed a FIFO slot on return.
        occ        = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_p1_q} - {2'b00, pop};
        rd_issue   = (state_q == S_STORE) && (cnt_q != store_len_q) && (occ < 3'd2);
    end

    always_comb begin
        state_d       = state_q;
        load_len_d    = load_len_q;
        store_len_d   = store_len_q;
        cnt_d         = cnt_q;
        pop_cnt_d     = pop_cnt_q;
        tlast_err_d   = tlast_err_q;
        rd_vld_p1_d   = rd_issue;
        fifo_data_d   = fifo_data_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_len_d  = load_len;
                    store_len_d = store_len;
                    tlast_err_d = 1'b0;
                    cnt_d       = '0;
                    pop_cnt_d   = '0;
                    state_d     = (load_len != '0) ? S_LOAD : S_CSTART;
                end
            end
            S_LOAD: begin
                if (mm2s_hs) begin
                    cnt_d = cnt_q + LEN_ONE;
                    if (bus.mm2s_tlast != last_load) tlast_err_d = 1'b1;
                    if (last_load) begin
                        cnt_d   = '0;
                        state_d = S_CSTART;
                    end
                end
            end
            S_CSTART: state_d = S_WAIT;
            S_WAIT: begin
                if (compute_done) state_d = (store_len_q != '0) ? S_STORE : S_FIN;
            end
            S_STORE: begin
                if (rd_issue) cnt_d = cnt_q + LEN_ONE;
                if (last_pop) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            fifo_data_d[fifo_wr_ptr_q] = bus.bank_rd_data;
            fifo_wr_ptr_d              = ~fifo_wr_ptr_q;
        end
        if (pop) begin
            fifo_rd_ptr_d = ~fifo_rd_ptr_q;
            pop_cnt_d     = pop_cnt_q + LEN_ONE;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q        <= S_IDLE;
            load_len_q     <= '0;
            store_len_q    <= '0;
            cnt_q          <= '0;
            pop_cnt_q      <= '0;
            tlast_err_q    <= 1'b0;
            rd_vld_p1_q    <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_rd_ptr_q  <= 1'b0;
            fifo_wr_ptr_q  <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            state_q        <= state_d;
            load_len_q     <= load_len_d;
            store_len_q    <= store_len_d;
            cnt_q          <= cnt_d;
            pop_cnt_q      <= pop_cnt_d;
            tlast_err_q    <= tlast_err_d;
            rd_vld_p1_q    <= rd_vld_p1_d;
            fifo_data_q    <= fifo_data_d;
            fifo_rd_ptr_q  <= fifo_rd_ptr_d;
            fifo_wr_ptr_q  <= fifo_wr_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FIN);
    assign compute_start = (state_q == S_CSTART);
    assign tlast_err     = tlast_err_q;

    assign bus.mm2s_tready  = (state_q == S_LOAD);
    assign bus.bank_wr_en   = mm2s_hs;
    assign bus.bank_wr_addr = mm2s_hs ? ADDR_WIDTH'(cnt_q) : '0;
    assign bus.bank_wr_data = mm2s_hs ? bus.mm2s_tdata : '0;

    assign bus.bank_rd_en   = rd_issue;
    assign bus.bank_rd_addr = rd_issue ? ADDR_WIDTH'(cnt_q) : '0;

    // The FIFO head's word index equals the number of words already popped.
    assign bus.s2mm_tvalid = s2mm_valid;
    assign bus.s2mm_tdata  = s2mm_valid ? fifo_data_q[fifo_rd_ptr_q] : '0;
    assign bus.s2mm_tlast  = s2mm_valid && (pop_cnt_q == store_len_q - LEN_ONE);
endmodule

// File: tb/tb_stream_frame_sequencer.sv
// Directed frame-level bench for stream_frame_sequencer with a result-bank model
// that returns a known pattern one cycle after each read.
module tb_stream_frame_sequencer;
    localparam int DW = 20;
    localparam int AW = 10;
    localparam int LW = 10;

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic [LW-1:0] load_len;
    logic [LW-1:0] store_len;
    logic          busy;
    logic          done;
    logic          tlast_err;
    logic          compute_start;
    logic          compute_done;

    int n_checks = 0;
    int n_pass   = 0;

    stream_frame_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    stream_frame_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .load_len      (load_len),
        .store_len     (store_len),
        .busy          (busy),
        .done          (done),
        .tlast_err     (tlast_err),
        .compute_start (compute_start),
        .compute_done  (compute_done),
        .bus           (bus)
    );

    always #5 aclk = ~aclk;

    function automatic logic [DW-1:0] src_dat(input int i);
        return DW'(32'h30000 + i * 257);
    endfunction

    function automatic logic [DW-1:0] rd_pat(input int a);
        return DW'(32'h5A000 + a * 7);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // mode: 0 = tready high, 1 = tready pattern 1,0,0,1, 2 = tready low
    task automatic run_frame(input int ll, input int sl, input int tlast_at, input int dly,
                             input int mode, input bit inject, input bit abort,
                             input bit exp_err);
        int src_idx = 0, wr_n = 0, out_n = 0, cs_cnt = 0, cs_cyc = -1, done_cnt = 0;
        int done_cyc = -1, first_tv = -1, rdy_cnt = 0, rd_cnt = 0, tv_cnt = 0;
        int issued = 0, popped = 0, max_occ = 0, viol = 0, pend_addr = 0;
        bit pend = 0, prev_stall = 0, fin = 0, aborted = 0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;

        @(posedge aclk); #1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            bus.bank_rd_data = pend ? rd_pat(pend_addr) : DW'(32'hBAD0);
            pend = 0;
            if (cyc == 0) begin
                start = 1'b1; load_len = LW'(ll); store_len = LW'(sl);
            end else if (inject && cs_cyc >= 0 && cyc == cs_cyc + 2) begin
                start = 1'b1; load_len = LW'(7); store_len = LW'(1);
            end else begin
                start = 1'b0;
            end
            bus.mm2s_tvalid = (src_idx < ll);
            bus.mm2s_tdata  = src_dat(src_idx);
            bus.mm2s_tlast  = (src_idx == tlast_at);
            case (mode)
                0:       bus.s2mm_tready = 1'b1;
                1:       bus.s2mm_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus.s2mm_tready = 1'b0;
            endcase
            compute_done = (cs_cyc >= 0) && (cyc == cs_cyc + dly);
            areset = abort && (first_tv >= 0) && (cyc == first_tv + 2);
            #4;
            if (bus.mm2s_tready) rdy_cnt++;
            if (bus.bank_wr_en) begin
                check("wr_addr", 32'(bus.bank_wr_addr), 32'(wr_n));
                check("wr_data", 32'(bus.bank_wr_data), 32'(src_dat(wr_n)));
                wr_n++;
            end
            if (bus.mm2s_tvalid && bus.mm2s_tready) src_idx++;
            if (compute_start) begin cs_cnt++; cs_cyc = cyc; end
            if (bus.bank_rd_en) begin
                check("rd_addr", 32'(bus.bank_rd_addr), 32'(rd_cnt));
                rd_cnt++; issued++; pend = 1; pend_addr = int'(bus.bank_rd_addr);
            end
            if (bus.s2mm_tvalid) begin
                tv_cnt++;
                if (first_tv < 0) first_tv = cyc;
            end
            if (prev_stall && !(bus.s2mm_tvalid && bus.s2mm_tdata == prev_data &&
                                bus.s2mm_tlast == prev_last)) viol++;
            if (bus.s2mm_tvalid && bus.s2mm_tready) begin
                check("s2mm_data", 32'(bus.s2mm_tdata), 32'(rd_pat(out_n)));
                check("s2mm_last", 32'(bus.s2mm_tlast), 32'(out_n == sl - 1));
                out_n++; popped++;
            end
            prev_stall = bus.s2mm_tvalid && !bus.s2mm_tready;
            prev_data  = bus.s2mm_tdata;
            prev_last  = bus.s2mm_tlast;
            if (issued - popped > max_occ) max_occ = issued - popped;
            if (done) begin done_cnt++; done_cyc = cyc; fin = 1; end
            @(posedge aclk); #1;
            if (areset) begin aborted = 1; break; end
            if (fin) break;
        end
        start = 1'b0; compute_done = 1'b0; areset = 1'b0; bus.mm2s_tvalid = 1'b0;
        #4;
        if (abort) begin
            check("abort_seen", 32'(aborted), 32'd1);
            check("abort_outputs", 32'({busy, done, tlast_err, compute_start, bus.mm2s_tready,
                                        bus.bank_wr_en, bus.bank_rd_en, bus.s2mm_tvalid,
                                        bus.s2mm_tlast}), 32'd0);
            check("abort_tdata", 32'(bus.s2mm_tdata), 32'd0);
        end else begin
            check("frame_end", 32'(fin), 32'd1);
            check("busy_after", 32'(busy), 32'd0);
            check("done_one_cycle", 32'(done), 32'd0);
            check("wr_count", 32'(wr_n), 32'(ll));
            check("mm2s_ready_cycles", 32'(rdy_cnt), 32'(ll));
            check("cs_count", 32'(cs_cnt), 32'd1);
            check("cs_cycle", 32'(cs_cyc), 32'(1 + ll));
            check("done_count", 32'(done_cnt), 32'd1);
            check("rd_count", 32'(rd_cnt), 32'(sl));
            check("out_count", 32'(out_n), 32'(sl));
            check("tlast_err", 32'(tlast_err), 32'(exp_err));
            check("stall_stable", 32'(viol), 32'd0);
            check("occ_le_2", 32'(max_occ <= 2), 32'd1);
            if (sl > 0) check("first_tvalid", 32'(first_tv), 32'(cs_cyc + dly + 3));
            else        check("no_tvalid", 32'(tv_cnt), 32'd0);
            if (mode == 0)
                check("done_cycle", 32'(done_cyc), 32'(cs_cyc + dly + ((sl == 0) ? 1 : 3 + sl)));
        end
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; load_len = '0; store_len = '0; compute_done = 1'b0;
        bus.mm2s_tdata = '0; bus.mm2s_tvalid = 1'b0; bus.mm2s_tlast = 1'b0;
        bus.bank_rd_data = '0; bus.s2mm_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        #4;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err_cs", 32'({done, tlast_err, compute_start}), 32'd0);
        check("rst_mm2s_tready", 32'(bus.mm2s_tready), 32'd0);
        check("rst_s2mm_bank", 32'({bus.s2mm_tvalid, bus.bank_rd_en, bus.bank_wr_en}), 32'd0);

        // ll, sl, tlast_at, dly, mode, inject, abort, exp_err
        run_frame(4, 4, 3, 5, 0, 0, 0, 0);
        run_frame(3, 2, 1, 2, 0, 0, 0, 1);
        repeat (3) @(posedge aclk);
        #1;
        check("tlast_err_sticky", 32'(tlast_err), 32'd1);
        run_frame(2, 6, 1, 3, 1, 0, 0, 0);
        run_frame(0, 0, -1, 1, 0, 0, 0, 0);
        run_frame(2, 3, 1, 5, 0, 1, 0, 0);
        run_frame(1, 4, 0, 2, 2, 0, 1, 0);
        run_frame(4, 4, 3, 5, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/stream_frame_sequencer.md
Name: stream_frame_sequencer

Overview:
- Sequences one processing frame around the MM2S/S2MM AXI-Stream FIFO pair.
- LOAD: drains a fixed number of words from the MM2S FIFO master side into a local operand bank.
- COMPUTE: pulses the compute core, then waits for its completion.
- STORE: reads results from the result bank and streams them into the S2MM FIFO slave side, generating tlast on the final word.

Parameters:
- DATA_WIDTH, 20, stream word and bank data width.
- ADDR_WIDTH, 10, bank address width.
- LEN_WIDTH, 10, width of frame length inputs; max frame is 2^LEN_WIDTH-1 words.

Ports:
- aclk in 1: single clock.
- areset in 1: synchronous, active-high reset.
- start in 1: begin frame; sampled only in IDLE.
- load_len in LEN_WIDTH: words to load; latched on start.
- store_len in LEN_WIDTH: words to store; latched on start.
- busy out 1: high in every state except IDLE.
- done out 1: one-cycle pulse at frame end.
- tlast_err out 1: sticky tlast mismatch flag; cleared on accepted start.
- mm2s_tdata in DATA_WIDTH; mm2s_tvalid in 1; mm2s_tlast in 1; mm2s_tready out 1.
- bank_wr_en out 1; bank_wr_addr out ADDR_WIDTH; bank_wr_data out DATA_WIDTH.
- compute_start out 1: one-cycle pulse.
- compute_done in 1: level or pulse; first high cycle in WAIT is honoured.
- bank_rd_en out 1; bank_rd_addr out ADDR_WIDTH; bank_rd_data in DATA_WIDTH (valid exactly 1 cycle after bank_rd_en).
- s2mm_tdata out DATA_WIDTH; s2mm_tvalid out 1; s2mm_tlast out 1; s2mm_tready in 1.

Behaviour:
- Reset: state=IDLE; all outputs 0; counters, output buffer and tlast_err cleared. Reset mid-frame aborts immediately; in-flight read data and buffered words are dropped.
- States: IDLE, LOAD, CSTART, WAIT, STORE, FIN.
- IDLE: start=1 latches both lengths, clears tlast_err. Next state is LOAD if load_len!=0, else CSTART. start in any other state is ignored.
- LOAD: mm2s_tready=1. Each handshake (tvalid&tready) drives bank_wr_en=1 combinationally, with bank_wr_addr=load count (from 0) and bank_wr_data=mm2s_tdata.
  - On the handshake where count==load_len-1: next state is CSTART.
  - tlast check: tlast_err sets if tlast=1 on any earlier word, or tlast=0 on the final word.
  - Length, not tlast, terminates LOAD.
  - No words are accepted outside LOAD.
- CSTART: compute_start=1 for exactly one cycle; next state WAIT.
- WAIT: compute_done=1 -> STORE if store_len!=0, else FIN.
- STORE: uses a 2-entry output FIFO plus a 1-cycle read pipeline.
  - A read is issued (bank_rd_en=1, addr=read count from 0) when reads remain and (entries + inflight − pop_this_cycle) < 2.
  - Returned data is pushed the cycle after the read.
  - s2mm_tdata, s2mm_tvalid and s2mm_tlast come from the FIFO head. s2mm_tlast=1 only on the word with index store_len-1.
  - Throughput is 1 word/cycle with tready held high. First s2mm_tvalid appears 2 cycles after STORE entry.
  - tvalid, once high, stays high with stable data/tlast until tready.
  - After the last-word handshake: next state FIN.
- FIN: done=1 for one cycle; next state IDLE. busy=0 from the IDLE cycle onward.
- Counters are LEN_WIDTH wide. Addresses take the low ADDR_WIDTH bits of the counter and wrap silently if LEN_WIDTH>ADDR_WIDTH.
- Simultaneous push and pop on a full output FIFO is legal; occupancy is unchanged.

Test Plan:
- start, load_len=4, store_len=4, tvalid continuous, tlast on word 3, compute_done 5 cycles after compute_start, tready=1
  -> bank_wr_addr 0..3; single compute_start pulse; s2mm words 0..3 on consecutive cycles, tlast on the 4th; done pulse; tlast_err=0.
- load_len=3, tlast asserted on word 1
  -> all 3 words still written; tlast_err=1 until the next start.
- store_len=6, tready toggling 1,0,0,1,…
  -> no word lost or duplicated; data/tlast stable while stalled; bank_rd_en never overruns the 2-entry buffer.
- load_len=0, store_len=0
  -> IDLE → CSTART → WAIT → FIN; no mm2s_tready, no bank access, no s2mm_tvalid.
- areset asserted mid-STORE with 2 buffered words
  -> next cycle all outputs 0, state IDLE; a new start runs a clean frame.
- start pulsed during WAIT
  -> ignored; latched lengths unchanged.
